// File: rtl/csr_exec_unit.sv
// Zicsr execute unit: EX read-modify-write with M/WB forwarding, bank write and rd writeback in WB.
// Optional build macro CSR_ILLEGAL_CHECK_EN restricts legal CSRs to the cycle/instret counters.
module csr_exec_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            ex_valid,
  input  logic [2:0]      ex_funct3,
  input  logic [11:0]     ex_csr_addr,
  input  logic [4:0]      ex_rs1_idx,
  input  logic [XLEN-1:0] ex_rs1_data,
  input  logic [4:0]      ex_rd_idx,
  input  logic            stall,
  input  logic            flush,
  output logic [11:0]     csr_raddr,
  input  logic [XLEN-1:0] csr_rdata,
  output logic            csr_wen,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            wb_rd_wen,
  output logic [4:0]      wb_rd_idx,
  output logic [XLEN-1:0] wb_rd_data,
  output logic            wb_illegal
);

  // funct3[1:0] selects the operation; funct3[2] selects the immediate operand.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RW   = 2'b01,
    OP_RS   = 2'b10,
    OP_RC   = 2'b11
  } op_e;

  typedef struct packed {
    logic            valid;
    logic            write;
    logic [11:0]     addr;
    logic [XLEN-1:0] wdata;
    logic [4:0]      rd_idx;
    logic [XLEN-1:0] rd_data;
    logic            illegal;
  } stage_t;

  stage_t m_d, m_q;
  stage_t wb_d, wb_q;

  op_e             ex_op;
  logic [XLEN-1:0] ex_src;
  logic [XLEN-1:0] ex_old;
  logic [XLEN-1:0] ex_new;
  logic            ex_write;
  logic            ex_illegal;
  logic            fwd_m;
  logic            fwd_wb;

  assign csr_raddr = ex_csr_addr;
  assign ex_op     = op_e'(ex_funct3[1:0]);
  assign ex_src    = ex_funct3[2] ? {{(XLEN-5){1'b0}}, ex_rs1_idx} : ex_rs1_data;
  assign ex_write  = (ex_op == OP_RW) || (ex_rs1_idx != 5'd0);

`ifdef CSR_ILLEGAL_CHECK_EN
  always_comb begin
    ex_illegal = 1'b1;
    unique case (ex_csr_addr)
      12'hC00, 12'hC80, 12'hC02, 12'hC82: ex_illegal = 1'b0;
      default:                            ex_illegal = 1'b1;
    endcase
  end
`else
  assign ex_illegal = 1'b0;
`endif

  // Forwarded values are the exact written data, so a counter read right after
  // a write to it sees that value rather than the bank's later increments.
  assign fwd_m  = m_q.valid  && m_q.write  && !m_q.illegal  && (m_q.addr  == ex_csr_addr);
  assign fwd_wb = wb_q.valid && wb_q.write && !wb_q.illegal && (wb_q.addr == ex_csr_addr);

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    ex_old = csr_rdata;
    if (fwd_m)       ex_old = m_q.wdata;
    else if (fwd_wb) ex_old = wb_q.wdata;

    ex_new = ex_src;
    unique case (ex_op)
      OP_RS:   ex_new = ex_old | ex_src;
      OP_RC:   ex_new = ex_old & ~ex_src;
      default: ex_new = ex_src;
    endcase
  end

  always_comb begin
    m_d         = '0;
    m_d.valid   = ex_valid && (ex_op != OP_NONE) && !stall && !flush;
    m_d.write   = ex_write;
    m_d.addr    = ex_csr_addr;
    m_d.wdata   = ex_new;
    m_d.rd_idx  = ex_rd_idx;
    m_d.rd_data = ex_old;
    m_d.illegal = ex_illegal;

    wb_d       = m_q;
    wb_d.valid = m_q.valid && !flush;
  end

  // NOTE: pipeline state uses non-blocking assignments; data fields are reset
  // too because they drive the write and writeback ports directly.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      m_q  <= '0;
      wb_q <= '0;
    end else begin
      m_q  <= m_d;
      wb_q <= wb_d;
    end
  end

  assign csr_wen    = wb_q.valid && wb_q.write && !wb_q.illegal;
  assign csr_waddr  = wb_q.addr;
  assign csr_wdata  = wb_q.wdata;
  assign wb_rd_wen  = wb_q.valid && (wb_q.rd_idx != 5'd0) && !wb_q.illegal;
  assign wb_rd_idx  = wb_q.rd_idx;
  assign wb_rd_data = wb_q.rd_data;
  assign wb_illegal = wb_q.valid && wb_q.illegal;

endmodule

// File: tb/tb_csr_exec_unit.sv
// Directed self-checking bench for csr_exec_unit: RMW ops, forwarding, stall/flush, reset, illegal access.
module tb_csr_exec_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            nrst;
  logic            ex_valid;
  logic [2:0]      ex_funct3;
  logic [11:0]     ex_csr_addr;
  logic [4:0]      ex_rs1_idx;
  logic [XLEN-1:0] ex_rs1_data;
  logic [4:0]      ex_rd_idx;
  logic            stall;
  logic            flush;
  logic [11:0]     csr_raddr;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_wen;
  logic [11:0]     csr_waddr;
  logic [XLEN-1:0] csr_wdata;
  logic            wb_rd_wen;
  logic [4:0]      wb_rd_idx;
  logic [XLEN-1:0] wb_rd_data;
  logic            wb_illegal;

  int n_tests = 0;
  int n_fail  = 0;

  csr_exec_unit #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .ex_valid    (ex_valid),
    .ex_funct3   (ex_funct3),
    .ex_csr_addr (ex_csr_addr),
    .ex_rs1_idx  (ex_rs1_idx),
    .ex_rs1_data (ex_rs1_data),
    .ex_rd_idx   (ex_rd_idx),
    .stall       (stall),
    .flush       (flush),
    .csr_raddr   (csr_raddr),
    .csr_rdata   (csr_rdata),
    .csr_wen     (csr_wen),
    .csr_waddr   (csr_waddr),
    .csr_wdata   (csr_wdata),
    .wb_rd_wen   (wb_rd_wen),
    .wb_rd_idx   (wb_rd_idx),
    .wb_rd_data  (wb_rd_data),
    .wb_illegal  (wb_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] f3, input logic [11:0] addr, input logic [4:0] rs1,
                       input logic [31:0] rs1_data, input logic [4:0] rd, input logic [31:0] rdata);
    ex_valid    = 1'b1;
    ex_funct3   = f3;
    ex_csr_addr = addr;
    ex_rs1_idx  = rs1;
    ex_rs1_data = rs1_data;
    ex_rd_idx   = rd;
    csr_rdata   = rdata;
  endtask

  task automatic idle();
    ex_valid  = 1'b0;
    csr_rdata = 32'h0;
  endtask

  task automatic check_wb(input string tag, input logic wen, input logic [11:0] waddr,
                          input logic [31:0] wdata, input logic rd_wen, input logic [4:0] rd_idx,
                          input logic [31:0] rd_data);
    check({tag, ".csr_wen"}, {31'd0, csr_wen}, {31'd0, wen});
    if (wen) begin
      check({tag, ".csr_waddr"}, {20'd0, csr_waddr}, {20'd0, waddr});
      check({tag, ".csr_wdata"}, csr_wdata, wdata);
    end
    check({tag, ".wb_rd_wen"}, {31'd0, wb_rd_wen}, {31'd0, rd_wen});
    if (rd_wen) begin
      check({tag, ".wb_rd_idx"}, {27'd0, wb_rd_idx}, {27'd0, rd_idx});
      check({tag, ".wb_rd_data"}, wb_rd_data, rd_data);
    end
    check({tag, ".wb_illegal"}, {31'd0, wb_illegal}, 32'd0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".csr_wen"}, {31'd0, csr_wen}, 32'd0);
    check({tag, ".wb_rd_wen"}, {31'd0, wb_rd_wen}, 32'd0);
    check({tag, ".wb_illegal"}, {31'd0, wb_illegal}, 32'd0);
  endtask

  initial begin
    nrst = 1'b0; stall = 1'b0; flush = 1'b0;
    idle();
    ex_funct3 = 3'b000; ex_csr_addr = 12'hABC; ex_rs1_idx = 5'd0;
    ex_rs1_data = 32'h0; ex_rd_idx = 5'd0;
    tick(); tick();

    // Reset state
    check_quiet("reset");
    check("reset.csr_waddr", {20'd0, csr_waddr}, 32'd0);
    check("reset.csr_wdata", csr_wdata, 32'd0);
    check("reset.wb_rd_idx", {27'd0, wb_rd_idx}, 32'd0);
    check("reset.wb_rd_data", wb_rd_data, 32'd0);
    check("reset.csr_raddr", {20'd0, csr_raddr}, 32'h0ABC);
    nrst = 1'b1;
    tick();

    // CSRRW 0xC00, rd=x5
    issue(3'b001, 12'hC00, 5'd3, 32'h1234_5678, 5'd5, 32'h10);
    #1 check("rw.csr_raddr", {20'd0, csr_raddr}, 32'h0C00);
    tick(); idle();
    check_quiet("rw.m_stage");
    tick();
    check_wb("rw", 1'b1, 12'hC00, 32'h1234_5678, 1'b1, 5'd5, 32'h10);
    tick();
    check_quiet("rw.one_cycle");

    // CSRRS 0xC02 with rs1=x0: read only
    issue(3'b010, 12'hC02, 5'd0, 32'hFFFF_FFFF, 5'd6, 32'hDEAD_BEEF);
    tick(); idle(); tick();
    check_wb("rs_x0", 1'b0, 12'h0, 32'h0, 1'b1, 5'd6, 32'hDEAD_BEEF);
    tick();

    // Back-to-back CSRRWI then CSRRSI on 0xC80 (M forwarding)
    issue(3'b101, 12'hC80, 5'd5, 32'hFFFF_0000, 5'd7, 32'hAAAA);
    tick();
    issue(3'b110, 12'hC80, 5'd2, 32'hFFFF_0000, 5'd8, 32'h5555);
    tick(); idle();
    check_wb("rwi", 1'b1, 12'hC80, 32'h5, 1'b1, 5'd7, 32'hAAAA);
    tick();
    check_wb("rsi_fwd_m", 1'b1, 12'hC80, 32'h7, 1'b1, 5'd8, 32'h5);
    tick();

    // CSRRC 0xC82 with prior write (0xFF, rd=x0) in WB (WB forwarding)
    issue(3'b001, 12'hC82, 5'd1, 32'hFF, 5'd0, 32'h0);
    tick(); idle(); tick();
    issue(3'b011, 12'hC82, 5'd2, 32'hF, 5'd9, 32'h1);
    check_wb("rw_rd_x0", 1'b1, 12'hC82, 32'hFF, 1'b0, 5'd0, 32'h0);
    tick(); idle(); tick();
    check_wb("rc_fwd_wb", 1'b1, 12'hC82, 32'hF0, 1'b1, 5'd9, 32'hFF);
    tick();

    // M forwarding takes priority over WB
    issue(3'b001, 12'hC00, 5'd1, 32'h11, 5'd0, 32'h0);
    tick();
    issue(3'b001, 12'hC00, 5'd1, 32'h22, 5'd0, 32'h0);
    tick();
    issue(3'b110, 12'hC00, 5'd1, 32'h0, 5'd10, 32'h99);
    check_wb("prio.op1", 1'b1, 12'hC00, 32'h11, 1'b0, 5'd0, 32'h0);
    tick(); idle();
    check_wb("prio.op2", 1'b1, 12'hC00, 32'h22, 1'b0, 5'd0, 32'h0);
    tick();
    check_wb("prio.op3", 1'b1, 12'hC00, 32'h23, 1'b1, 5'd10, 32'h22);
    tick();

    // Flush the cycle after issue
    issue(3'b001, 12'hC00, 5'd1, 32'h55, 5'd5, 32'h0);
    tick(); idle(); flush = 1'b1;
    tick(); flush = 1'b0;
    check_quiet("flush_m");

    // Stall at issue
    issue(3'b001, 12'hC00, 5'd1, 32'h66, 5'd5, 32'h0);
    stall = 1'b1;
    tick(); idle(); stall = 1'b0;
    tick();
    check_quiet("stall");

    // Stall and flush together at issue
    issue(3'b001, 12'hC00, 5'd1, 32'h67, 5'd5, 32'h0);
    stall = 1'b1; flush = 1'b1;
    tick(); idle(); stall = 1'b0; flush = 1'b0;
    tick();
    check_quiet("stall_flush");

    // Flush does not cancel an op already in WB
    issue(3'b001, 12'hC02, 5'd1, 32'h77, 5'd4, 32'h3);
    tick(); idle(); tick();
    flush = 1'b1;
    #1 check_wb("flush_wb", 1'b1, 12'hC02, 32'h77, 1'b1, 5'd4, 32'h3);
    tick(); flush = 1'b0;

    // Unused funct3 is a bubble
    issue(3'b000, 12'hC00, 5'd1, 32'h88, 5'd5, 32'h0);
    tick();
    issue(3'b100, 12'hC00, 5'd1, 32'h89, 5'd5, 32'h0);
    tick(); idle();
    check_quiet("funct3_000");
    tick();
    check_quiet("funct3_100");

    // Reset mid-operation drops in-flight ops
    issue(3'b001, 12'hC00, 5'd1, 32'h99, 5'd5, 32'h0);
    tick();
    issue(3'b001, 12'hC00, 5'd1, 32'h9A, 5'd5, 32'h0);
    nrst = 1'b0;
    tick(); idle(); nrst = 1'b1;
    check_quiet("reset_mid.wb");
    tick();
    check_quiet("reset_mid.m");

    // Access to a non-counter CSR
    issue(3'b001, 12'h300, 5'd1, 32'hABCD, 5'd5, 32'h42);
    tick(); idle(); tick();
`ifdef CSR_ILLEGAL_CHECK_EN
    check("illegal.wb_illegal", {31'd0, wb_illegal}, 32'd1);
    check("illegal.csr_wen", {31'd0, csr_wen}, 32'd0);
    check("illegal.wb_rd_wen", {31'd0, wb_rd_wen}, 32'd0);
`else
    check_wb("unchecked_addr", 1'b1, 12'h300, 32'hABCD, 1'b1, 5'd5, 32'h42);
`endif
    tick();
    check_quiet("illegal.after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_exec_unit.md
# csr_exec_unit

- Executes Zicsr instructions (CSRRW/S/C and immediate forms) for the pipeline, directly upstream of the CSR register bank.
- Drives the bank read port in EX and computes the read-modify-write value, forwarding from in-flight CSR ops.
- Carries the result through M and WB pipeline registers.
- Issues the bank write and the rd writeback in WB.

## Interface
Parameters:
- XLEN, 32, data width of CSRs, rs1 and rd data.

Ports:
- clk  in  1  clock
- nrst  in  1  reset, synchronous, active-low
- ex_valid  in  1  CSR instruction present in EX
- ex_funct3  in  3  001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
- ex_csr_addr  in  12  target CSR
- ex_rs1_idx  in  5  rs1 index; also the zimm field for immediate forms
- ex_rs1_data  in  XLEN  rs1 value (already GPR-forwarded)
- ex_rd_idx  in  5  destination GPR
- stall  in  1  EX held; M receives a bubble
- flush  in  1  kill the EX and M contents
- csr_raddr  out  12  bank read address, = ex_csr_addr
- csr_rdata  in  XLEN  bank read data (combinational)
- csr_wen, csr_waddr[11:0], csr_wdata[XLEN]  out  bank write port
- wb_rd_wen, wb_rd_idx[5], wb_rd_data[XLEN]  out  GPR writeback
- wb_illegal  out  1  illegal CSR access retired in WB

## Operation
- **EX operand:** src = ex_rs1_data for funct3[2]=0; otherwise src = zero-extended ex_rs1_idx.
- **EX old value (forwarding priority):**
  - M-stage op with write and same address → its wdata;
  - else WB-stage op with write and same address → its wdata;
  - else csr_rdata.
- **EX new value:**
  - RW: new = src.
  - RS: new = old | src.
  - RC: new = old & ~src.
- **Write enable:**
  - RW/RWI always write.
  - RS/RC/RSI/RCI write only when ex_rs1_idx != 0.
- **Read value:** rd value = old.
  - rd write enabled when ex_rd_idx != 0, for all ops. RW with rd=x0 still writes the CSR.
- **EX→M register, per posedge:**
  - captures {valid, write, addr, wdata, rd_idx, rd_data, illegal}.
  - valid = ex_valid & !stall & !flush.
- **M→WB register:** advances every cycle; valid = m_valid & !flush.
- **WB outputs:**
  - csr_wen = wb_valid & wb_write & !wb_illegal.
  - wb_rd_wen = wb_valid & rd_idx!=0 & !wb_illegal.
  - wb_illegal = wb_valid & illegal.
- **Reset:** all valid bits cleared; every output reset value is 0, except csr_raddr, which follows ex_csr_addr.
- **Forwarded counter values:** do not include the bank's free-running increments made after the older write. A read of cycle within 2 cycles of a write to cycle returns exactly the written value.
- **Unused combinations:** funct3 000/100 with ex_valid treated as a bubble (no write, no rd).

## Timing
- EX op accepted at edge N (ex_valid=1, stall=0) → M at N+1 → WB during cycle N+1..N+2.
- csr_wen and wb_rd_wen are high for exactly one cycle, the cycle after the M→WB edge. Bank update lands at edge N+2.
- Back-to-back ops on the same CSR at 1/cycle are fully supported via M/WB forwarding. No stall is ever requested.
- stall and flush in the same cycle: flush wins. Both M and WB receive bubbles.
- flush does not cancel an op already in WB.
- Reset mid-operation: in-flight ops are dropped, no write issued.

## Configuration
- **CSR_ILLEGAL_CHECK_EN defined:**
  - illegal = ex_csr_addr not in {0xC00 cycle, 0xC80 cycleh, 0xC02 instret, 0xC82 instreth}.
  - An illegal op suppresses the CSR write and the rd write, and pulses wb_illegal.
  - An illegal op is never a forwarding source.
- **Not defined:**
  - illegal is tied 0 and wb_illegal is constant 0.
  - Unknown addresses proceed; the bank aliases them.

## Test plan
- CSRRW 0xC00, rs1=0x1234_5678, rd=x5, csr_rdata=0x10 → two cycles later csr_wen=1, waddr=0xC00, wdata=0x12345678; wb_rd_data=0x10 to x5.
- CSRRS 0xC02 rs1=x0, rd=x6 → csr_wen stays 0; wb_rd_wen=1 with the bank value.
- Back-to-back: CSRRWI 0xC80 zimm=5, then CSRRSI 0xC80 zimm=2 next cycle → second wdata=7, second rd=5, regardless of csr_rdata.
- CSRRC 0xC82 rs1 value 0xF with the prior write still in WB (wdata 0xFF) → wdata=0xF0.
- flush asserted the cycle after issue → no csr_wen, no wb_rd_wen. stall at issue → same.
- With CSR_ILLEGAL_CHECK_EN, CSRRW to 0x300 → wb_illegal pulses 1 cycle; csr_wen=0, wb_rd_wen=0.
